// File: rtl/gcd_sched_pkg.sv
// -----------------------------------------------------------------------------
// gcd_sched_pkg
// Shared definitions for the GCD coprocessor scheduler:
//   - sched_state_t  : scheduler FSM state encoding
//   - TIMEOUT_CYCLES : WAIT_RES watchdog limit (used only when the
//                      GCD_SCHED_TIMEOUT_EN macro is defined)
//   - WD_W           : watchdog counter width
// -----------------------------------------------------------------------------
package gcd_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_A   = 3'd1,
    ST_SEND_B   = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_RESPOND  = 3'd4
  } sched_state_t;

  localparam int unsigned TIMEOUT_CYCLES = 5000;
  localparam int          WD_W           = 16;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// -----------------------------------------------------------------------------
// gcd_rr_arbiter
// Purely combinational round-robin picker. Searches upward from ptr with
// wrap-around and returns the first asserted request.
// Ports:
//   req   in  N      request vector
//   ptr   in  IDX_W  index where the search starts (highest priority)
//   grant out N      one-hot grant (all zero when nothing is requested)
//   idx   out IDX_W  binary index of the granted request
//   any   out 1      at least one request present
// -----------------------------------------------------------------------------
module gcd_rr_arbiter
  import gcd_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      // Candidate k steps above ptr, wrapped into 0..N-1.
      w_cand = IDX_W'((int'(ptr) + k) % N);
      if (!any && req[w_cand]) begin
        any           = 1'b1;
        idx           = w_cand;
        grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_fsl_scheduler.sv
// -----------------------------------------------------------------------------
// gcd_fsl_scheduler
// Shares one single-issue GCD coprocessor between NUM_REQ clients. One operand
// pair is granted at a time (round-robin), pushed as two FSL words (A then B),
// and the single result word is routed back to the granted client.
//
// Optional feature: define GCD_SCHED_TIMEOUT_EN to enable a WAIT_RES watchdog
// that answers with rsp_err=1 / rsp_data=0 after TIMEOUT_CYCLES cycles.
//
// Ports:
//   FSL_Clk     in   clock
//   FSL_Rst_n   in   asynchronous active-low reset
//   req_valid   in   [NUM_REQ]         requester i holds an operand pair
//   req_a/b     in   [NUM_REQ*DATA_W]  operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready   out  [NUM_REQ]         one-hot accept pulse (combinational)
//   rsp_valid   out  [NUM_REQ]         one-hot result pulse
//   rsp_data    out  [DATA_W]          result word
//   rsp_err     out  1                 timeout flag
//   cop_write   out  1                 write operand word into coprocessor
//   cop_data    out  [0:DATA_W-1]      operand word
//   cop_full    in   1                 coprocessor input FIFO full
//   cop_exists  in   1                 coprocessor result available
//   cop_result  in   [0:DATA_W-1]      coprocessor result word
//   cop_read    out  1                 consume result word (combinational)
// -----------------------------------------------------------------------------
module gcd_fsl_scheduler
  import gcd_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      FSL_Clk,
  input  logic                      FSL_Rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      cop_write,
  output logic [0:DATA_W-1]         cop_data,
  input  logic                      cop_full,
  input  logic                      cop_exists,
  input  logic [0:DATA_W-1]         cop_result,
  output logic                      cop_read
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t     r_state;
  sched_state_t     w_state_next;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_g;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_result;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_accept;

  // Per-requester operand views, so the latch below is a plain array select.
  logic [DATA_W-1:0] w_a_arr [NUM_REQ];
  logic [DATA_W-1:0] w_b_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
      assign w_b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
    end
  endgenerate

  gcd_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

`ifdef GCD_SCHED_TIMEOUT_EN
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;
  logic            w_wd_expired;

  // Expiry fires on the last WAIT_RES cycle of the budget; a result arriving
  // on that same cycle still wins.
  assign w_wd_expired = (r_state == ST_WAIT_RES) && !cop_exists &&
                        (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
    if (!FSL_Rst_n) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state != ST_WAIT_RES) begin
        r_wd_cnt <= '0;
      end else begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (r_state == ST_WAIT_RES) begin
        if (cop_exists) begin
          r_err <= 1'b0;
        end else if (w_wd_expired) begin
          r_err <= 1'b1;
        end
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
    if (!FSL_Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_data     = '0;
    rsp_err      = 1'b0;
    cop_write    = 1'b0;
    cop_data     = '0;
    cop_read     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The reset gate keeps the combinational outputs quiet while held in
        // reset. A pending stale result is drained before any new grant.
        if (FSL_Rst_n) begin
          if (cop_exists) begin
            cop_read = 1'b1;
          end else if (w_any) begin
            req_ready    = w_grant;
            w_accept     = 1'b1;
            w_state_next = ST_SEND_A;
          end
        end
      end
      ST_SEND_A: begin
        cop_write = 1'b1;
        cop_data  = r_a;
        if (!cop_full) w_state_next = ST_SEND_B;
      end
      ST_SEND_B: begin
        cop_write = 1'b1;
        cop_data  = r_b;
        if (!cop_full) w_state_next = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        cop_read = cop_exists;
        if (cop_exists) begin
          w_state_next = ST_RESPOND;
        end
`ifdef GCD_SCHED_TIMEOUT_EN
        else if (w_wd_expired) begin
          w_state_next = ST_RESPOND;
        end
`endif
      end
      ST_RESPOND: begin
        rsp_valid[r_g] = 1'b1;
        rsp_data       = r_result;
`ifdef GCD_SCHED_TIMEOUT_EN
        rsp_err        = r_err;
`endif
        w_state_next   = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Transaction datapath: latched grant, operands, result and rr pointer.
  always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
    if (!FSL_Rst_n) begin
      r_rr_ptr <= '0;
      r_g      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_g <= w_idx;
        r_a <= w_a_arr[w_idx];
        r_b <= w_b_arr[w_idx];
      end
      if (r_state == ST_WAIT_RES) begin
        if (cop_exists) begin
          r_result <= cop_result;
        end
`ifdef GCD_SCHED_TIMEOUT_EN
        else if (w_wd_expired) begin
          r_result <= '0;
        end
`endif
      end
      if (r_state == ST_RESPOND) begin
        r_rr_ptr <= (r_g == IDX_W'(NUM_REQ - 1)) ? '0 : r_g + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gcd_fsl_scheduler.sv
// -----------------------------------------------------------------------------
// tb_gcd_fsl_scheduler
// Self-checking bench: a reactive FSL coprocessor model (GCD with a
// configurable compute delay), a transaction-level scoreboard of the
// scheduler compared against the DUT on every negedge, directed scenarios
// with literal expectations, and a randomized phase.
// -----------------------------------------------------------------------------
module tb_gcd_fsl_scheduler;

  localparam int N = 4;
  localparam int W = 32;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*W-1:0]    req_a, req_b;
  logic [N-1:0]      req_ready, rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              cop_write, cop_full, cop_exists, cop_read;
  logic [0:W-1]      cop_data, cop_result;

  gcd_fsl_scheduler #(.NUM_REQ(N), .DATA_W(W)) dut (
    .FSL_Clk    (clk),
    .FSL_Rst_n  (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .cop_write  (cop_write),
    .cop_data   (cop_data),
    .cop_full   (cop_full),
    .cop_exists (cop_exists),
    .cop_result (cop_result),
    .cop_read   (cop_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] a, b, t;
    a = x;
    b = y;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // ---------------- coprocessor model ----------------
  int   cop_delay = 0;
  bit   cop_never = 0;
  bit   rand_mode = 0;
  logic [W-1:0] cop_in_q[$];
  logic [W-1:0] cop_out_q[$];
  bit   comp_busy = 0;
  int   comp_cnt  = 0;
  logic [W-1:0] comp_res;

  always @(posedge clk) begin
    logic [W-1:0] x, y, r;
    int d;
    if (cop_read && cop_out_q.size() > 0) void'(cop_out_q.pop_front());
    if (comp_busy) begin
      if (comp_cnt <= 1) begin
        cop_out_q.push_back(comp_res);
        comp_busy = 0;
      end else begin
        comp_cnt--;
      end
    end
    if (cop_write && !cop_full && !cop_never) cop_in_q.push_back(cop_data);
    if (!comp_busy && cop_in_q.size() >= 2) begin
      x = cop_in_q.pop_front();
      y = cop_in_q.pop_front();
      r = gcd(x, y);
      d = rand_mode ? int'($urandom_range(0, 4)) : cop_delay;
      if (d == 0) cop_out_q.push_back(r);
      else begin
        comp_busy = 1;
        comp_cnt  = d;
        comp_res  = r;
      end
    end
    cop_exists <= (cop_out_q.size() > 0);
    cop_result <= (cop_out_q.size() > 0) ? cop_out_q[0] : '0;
  end

  // ---------------- scoreboard / monitor ----------------
  int cyc = 0, acc_cnt = 0, rsp_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  int acc_cyc = 0, acc_idx = -1, rsp_cyc = 0, rsp_idx = -1;
  logic [W-1:0] rsp_dat = '0;
  logic rsp_er = 1'b0;
  logic [N-1:0] seen_ready = '0;
  int log_idx[$];
  int log_dat[$];

  bit m_busy = 0, m_got = 0, m_err = 0;
  int m_g = 0, m_ws = 0, m_wcnt = 0, m_rr = 0;
  logic [W-1:0] m_a, m_b;

  always @(negedge clk) begin
    logic [N-1:0] e_ready, e_rsp;
    logic e_write, e_read, e_err;
    logic [W-1:0] e_cdata, e_rdata;
    int pick;
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_got = 0; m_err = 0; m_ws = 0; m_wcnt = 0; m_rr = 0;
    end
    e_ready = '0;
    pick = -1;
    if (rst_n && !m_busy && !cop_exists)
      for (int k = 0; k < N; k++)
        if (pick < 0 && req_valid[(m_rr + k) % N]) pick = (m_rr + k) % N;
    if (pick >= 0) e_ready[pick] = 1'b1;
    e_write = m_busy && m_ws < 2;
    e_cdata = !e_write ? '0 : ((m_ws == 0) ? m_a : m_b);
    e_read  = rst_n && cop_exists && (!m_busy || (m_ws == 2 && !m_got));
    e_rsp = '0; e_rdata = '0; e_err = 1'b0;
    if (m_busy && m_got) begin
      e_rsp[m_g] = 1'b1;
      e_err      = m_err;
      e_rdata    = m_err ? '0 : gcd(m_a, m_b);
    end
    chk("req_ready", req_ready, e_ready);
    chk("cop_write", cop_write, e_write);
    chk("cop_data",  cop_data,  e_cdata);
    chk("cop_read",  cop_read,  e_read);
    chk("rsp_valid", rsp_valid, e_rsp);
    chk("rsp_data",  rsp_data,  e_rdata);
    chk("rsp_err",   rsp_err,   e_err);

    // Event counters from the DUT, used by the directed literal checks.
    seen_ready = req_ready;
    if (req_ready != 0) begin
      acc_cnt++;
      acc_cyc = cyc;
      for (int i = 0; i < N; i++) if (req_ready[i]) acc_idx = i;
    end
    if (cop_write && !cop_full) wr_cnt++;
    if (cop_read) rd_cnt++;
    if (rsp_valid != 0) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      for (int i = 0; i < N; i++) if (rsp_valid[i]) rsp_idx = i;
      rsp_dat = rsp_data;
      rsp_er  = rsp_err;
      log_idx.push_back(rsp_idx);
      log_dat.push_back(int'(rsp_data));
      $display("rsp: req %0d data %0d err %0d cycle %0d", rsp_idx, rsp_data, rsp_err, cyc);
    end

    // Advance the transaction model for the coming edge.
    if (rst_n) begin
      if (!m_busy) begin
        if (pick >= 0) begin
          m_busy = 1; m_g = pick; m_ws = 0; m_got = 0; m_err = 0; m_wcnt = 0;
          m_a = req_a[pick*W +: W];
          m_b = req_b[pick*W +: W];
        end
      end else if (m_ws < 2) begin
        if (!cop_full) m_ws++;
      end else if (!m_got) begin
        if (cop_exists) m_got = 1;
`ifdef GCD_SCHED_TIMEOUT_EN
        else begin
          m_wcnt++;
          if (m_wcnt == 5000) begin
            m_got = 1;
            m_err = 1;
          end
        end
`endif
      end else begin
        m_busy = 0;
        m_rr   = (m_g + 1) % N;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (seen_ready[i]) req_valid[i] = 1'b0;
      if (rand_mode && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        int m;
        m = int'($urandom_range(1, 500));
        req_a[i*W +: W] = W'(m * int'($urandom_range(1, 60)));
        req_b[i*W +: W] = W'(m * int'($urandom_range(1, 60)));
        req_valid[i] = 1'b1;
      end
    end
    if (rand_mode) cop_full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_acc(input int target, input int max_cyc);
    for (int k = 0; k < max_cyc && acc_cnt < target; k++) tick();
    chk("wait_accept_bound", acc_cnt >= target, 1);
  endtask

  task automatic wait_rsp(input int target, input int max_cyc);
    for (int k = 0; k < max_cyc && rsp_cnt < target; k++) tick();
    chk("wait_response_bound", rsp_cnt >= target, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

  int t2_exp[4] = '{6, 7, 3, 4};

  initial begin
    int a0, r0, w0, d0, base;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    cop_full = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // All four requesters at once: served 0,1,2,3.
    cop_delay = 0;
    base = log_idx.size();
    set_req(0, 12, 18); set_req(1, 7, 21); set_req(2, 9, 6); set_req(3, 8, 20);
    wait_rsp(rsp_cnt + 4, 100);
    for (int k = 0; k < 4; k++) begin
      chk("t2_order_idx", log_idx[base + k], k);
      chk("t2_order_data", log_dat[base + k], t2_exp[k]);
    end
    repeat (2) tick();

    // Single request, 3-cycle coprocessor: response 7 cycles after accept.
    cop_delay = 3;
    r0 = rsp_cnt;
    set_req(2, 15, 45);
    wait_rsp(r0 + 1, 50);
    chk("t1_grant_idx", acc_idx, 2);
    chk("t1_rsp_idx", rsp_idx, 2);
    chk("t1_latency", rsp_cyc - acc_cyc, 7);
    chk("t1_data", rsp_dat, 15);
    chk("t1_err", rsp_er, 0);
    repeat (2) tick();

    // cop_full held 5 cycles during SEND_B.
    cop_delay = 0;
    r0 = rsp_cnt; a0 = acc_cnt; w0 = wr_cnt;
    set_req(3, 36, 48);
    wait_acc(a0 + 1, 20);
    tick();
    cop_full = 1'b1;
    repeat (5) tick();
    cop_full = 1'b0;
    wait_rsp(r0 + 1, 50);
    chk("t3_latency", rsp_cyc - acc_cyc, 9);
    chk("t3_data", rsp_dat, 12);
    chk("t3_writes", wr_cnt - w0, 2);
    repeat (2) tick();

    // Reset in WAIT_RES; stale result drained; then req 1 gets gcd(10,4).
    cop_delay = 10;
    r0 = rsp_cnt; a0 = acc_cnt;
    set_req(0, 15, 45);
    wait_acc(a0 + 1, 20);
    repeat (3) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    d0 = rd_cnt;
    for (int k = 0; k < 40 && rd_cnt == d0; k++) tick();
    chk("t4_drained", rd_cnt - d0, 1);
    chk("t4_no_rsp_after_abort", rsp_cnt, r0);
    cop_delay = 0;
    set_req(1, 10, 4);
    wait_rsp(r0 + 1, 50);
    chk("t4_rsp_idx", rsp_idx, 1);
    chk("t4_data", rsp_dat, 2);
    chk("t4_reads", rd_cnt - d0, 2);
    repeat (3) tick();
    chk("t4_single_rsp", rsp_cnt, r0 + 1);

    // Randomized traffic with random backpressure and compute delay.
    a0 = acc_cnt; r0 = rsp_cnt;
    rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0;
    cop_full = 1'b0;
    for (int k = 0; k < 1000 && !(req_valid == 0 && (acc_cnt - a0) == (rsp_cnt - r0)); k++) tick();
    chk("rand_all_served", (acc_cnt - a0) == (rsp_cnt - r0) && req_valid == 0, 1);
    chk("rand_some_traffic", (rsp_cnt - r0) > 20, 1);
    repeat (3) tick();

    // Coprocessor never answers.
    cop_never = 1;
    r0 = rsp_cnt; a0 = acc_cnt;
    set_req(1, 100, 75);
    wait_acc(a0 + 1, 20);
`ifdef GCD_SCHED_TIMEOUT_EN
    wait_rsp(r0 + 1, 5100);
    chk("t5_rsp_idx", rsp_idx, 1);
    chk("t5_err", rsp_er, 1);
    chk("t5_data", rsp_dat, 0);
    chk("t5_latency", rsp_cyc - acc_cyc, 5003);
`else
    repeat (300) tick();
    chk("t5_no_rsp", rsp_cnt, r0);
`endif
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    cop_never = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/gcd_fsl_scheduler.md
# gcd_fsl_scheduler

Multi-requester front end that shares one `gcd_coprocessor` instance across `NUM_REQ` clients. It sits between the client logic and the coprocessor's FSL slave/master FIFOs. It grants one operand pair at a time in round-robin order and pushes the two operands into the coprocessor. It then collects the single result word and routes it back to the granted client.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 32: operand/result width.
- `FSL_Clk`  in  1  single clock for the block and the coprocessor FSL links.
- `FSL_Rst_n`  in  1  reset; one clock, reset asynchronous, active-low.
- `req_valid`  in  NUM_REQ  requester i holds an operand pair.
- `req_a`, `req_b`  in  NUM_REQ*DATA_W  operands; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  one-hot accept pulse.
- `rsp_valid`  out  NUM_REQ  one-hot result pulse.
- `rsp_data`  out  DATA_W  result, valid with `rsp_valid`.
- `rsp_err`  out  1  timeout flag, valid with `rsp_valid`.
- `cop_write`  out  1  drives coprocessor `FSL_S_Exists` path (write into its slave FIFO).
- `cop_data`  out  [0:DATA_W-1]  operand word to coprocessor.
- `cop_full`  in  1  coprocessor input FIFO full.
- `cop_exists`  in  1  coprocessor `FSL_M_Write`/result available.
- `cop_result`  in  [0:DATA_W-1]  coprocessor `FSL_M_Data`.
- `cop_read`  out  1  consume result word.

## Operation
- States: IDLE, SEND_A, SEND_B, WAIT_RES, RESPOND. Single transaction in flight; the coprocessor is single-issue.
- IDLE:
  - If `cop_exists`=1, assert `cop_read`, discard the word, and grant nothing. This drains stale results after reset or timeout.
  - Otherwise, if any `req_valid`, grant g = first valid index searching upward from `rr_ptr` with wrap.
  - Assert `req_ready[g]` combinationally. Latch g, `req_a[g]` and `req_b[g]` on the edge. Go to SEND_A.
- SEND_A: `cop_write`=1, `cop_data`=A. Advance to SEND_B on an edge with `cop_full`=0. Hold while full.
- SEND_B: same as SEND_A with B; advance to WAIT_RES.
- WAIT_RES: `cop_read`=`cop_exists`. On an edge with `cop_exists`=1, latch `cop_result` and go to RESPOND.
- RESPOND: assert `rsp_valid[g]` for exactly one cycle with `rsp_data` and `rsp_err`. Set `rr_ptr` ← (g+1) mod NUM_REQ. Go to IDLE.
- Requesters may change operands after `req_ready`; the scheduler uses only the latched copies.
- Operands are passed through unmodified. Zero operands are the coprocessor's concern.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, latched operands/result=0.
  - All outputs are 0 during reset and in IDLE with no valid requester and `cop_exists`=0.
- Outputs are decoded from registered state. The only combinational input→output paths are `req_ready` (from `req_valid`, `rr_ptr`, `cop_exists`) and `cop_read` (from `cop_exists`).
- Minimum latency: accept at cycle 0, A written at 1, B at 2, result read at 3 (if ready), `rsp_valid` at 4.
  - Each `cop_full` cycle adds one cycle.
  - Each coprocessor compute cycle adds one cycle.
- Simultaneous requests are serialised. Back-to-back service of the same requester occurs only when no other requester is valid.
- Async reset mid-transaction aborts it with no response. Any leftover coprocessor result is drained in IDLE before the next grant.

## Configuration
- `GCD_SCHED_TIMEOUT_EN` defined: a 16-bit watchdog counts WAIT_RES cycles. At `TIMEOUT_CYCLES` (default 5000), go to RESPOND with `rsp_err`=1 and `rsp_data`=0. A late result is later drained in IDLE.
- Not defined: no counter; WAIT_RES waits indefinitely; `rsp_err` is tied 0.

## Structure
- Package `gcd_sched_pkg`: state encoding constants, `TIMEOUT_CYCLES`, and the counter width.
- Sub-module `gcd_rr_arbiter`: combinational round-robin picker (`req`, `ptr` → one-hot `grant`, `idx`, `any`).

## Test plan
- Single request, req 2 with A=15, B=45, coprocessor model returns 15 after 3 cycles → `req_ready[2]` at cycle 0, `rsp_valid[2]` with 15 at cycle 7, `rsp_err`=0.
- All 4 requesters valid at once, pairs (12,18),(7,21),(9,6),(8,20) → grant order 0,1,2,3; responses 6,7,3,4, each to the correct index.
- `cop_full` held for 5 cycles during SEND_B → B written once, no duplicate A, latency +5.
- Reset asserted in WAIT_RES, result 15 arrives after release, then req 1 requests (10,4) → 15 drained via `cop_read` with no `rsp_valid`; req 1 receives 2.
- With `GCD_SCHED_TIMEOUT_EN`, coprocessor never responds → `rsp_valid[g]` with `rsp_err`=1, `rsp_data`=0 after 5000 WAIT_RES cycles. Without the macro, no response is ever issued.
